qbert_rom_loader: RTL and testbench



---
 rtl/qbert_rom_pkg.sv | 36 +++
 rtl/qbert_rom_loader_if.sv | 25 ++
 rtl/rom_fifo2.sv | 51 +++++
 rtl/qbert_rom_loader.sv | 110 +++++++++++
 tb/tb_qbert_rom_loader.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qbert_rom_pkg.sv
// Shared types and constants for the Q*bert ROM download path.
// Region bases here are reused by the board-level address decoders.
package qbert_rom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } loader_state_t;

  localparam logic [3:0] REG_CPU = 4'b0001;
  localparam logic [3:0] REG_BG  = 4'b0010;
  localparam logic [3:0] REG_SPR = 4'b0100;
  localparam logic [3:0] REG_SND = 4'b1000;

  localparam int          DEF_ADDR_W  = 17;
  localparam logic [16:0] DEF_R1_BASE = 17'h0A000;
  localparam logic [16:0] DEF_R2_BASE = 17'h0E000;
  localparam logic [16:0] DEF_R3_BASE = 17'h16000;
  localparam logic [16:0] DEF_TOTAL   = 17'h17000;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_DIP = 8'd254;

  function automatic logic [3:0] decode_region(input logic [24:0] addr,
                                               input logic [24:0] r1,
                                               input logic [24:0] r2,
                                               input logic [24:0] r3);
    if (addr < r1)      return REG_CPU;
    else if (addr < r2) return REG_BG;
    else if (addr < r3) return REG_SPR;
    else                return REG_SND;
  endfunction

endpackage

// File: rtl/qbert_rom_loader_if.sv
// Bus bundles for the loader: the hps_io ioctl stream in, the ROM write stream out.
interface ioctl_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;

  modport master (output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
                  input  ioctl_wait);
  modport slave  (input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
                  output ioctl_wait);
endinterface

interface rom_if #(parameter int ADDR_W = 17);
  logic              rom_wr;
  logic              rom_ready;
  logic [3:0]        rom_region;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;

  modport master (output rom_wr, rom_region, rom_addr, rom_data, input rom_ready);
  modport slave  (input  rom_wr, rom_region, rom_addr, rom_data, output rom_ready);
endinterface

// File: rtl/rom_fifo2.sv
// Two-entry FIFO between the decoder and the ROM targets.
// level_next exposes post-edge occupancy so the stall flag can be registered.
module rom_fifo2 #(
  parameter int W = 29
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   level_next
);

  logic [W-1:0] mem [2];
  logic [1:0]   count;
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    level_next = count + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= level_next;
    end
  end

endmodule

// File: rtl/qbert_rom_loader.sv
// Decodes the index-0 ROM image into per-region writes through a 2-deep FIFO,
// captures the index-254 DIP byte and tracks done/error/checksum status.
module qbert_rom_loader
  import qbert_rom_pkg::*;
#(
  parameter int                ADDR_W  = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] R1_BASE = DEF_R1_BASE,
  parameter logic [ADDR_W-1:0] R2_BASE = DEF_R2_BASE,
  parameter logic [ADDR_W-1:0] R3_BASE = DEF_R3_BASE,
  parameter logic [ADDR_W-1:0] TOTAL   = DEF_TOTAL
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  ioctl_if.slave      ioctl,
  rom_if.master       rom,
  output logic        rom_init,
  output logic [7:0]  dip_sw,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] checksum
);

  localparam int FW = 4 + ADDR_W + 8;

  loader_state_t     state, state_next;
  logic              start, accept, in_range, push, pop, err_set;
  logic              enter_load, done_set, drain_hold;
  logic              fifo_full, fifo_empty;
  logic [1:0]        level_next;
  logic [3:0]        region;
  logic [ADDR_W-1:0] base, rel_addr;
  logic [FW-1:0]     fifo_din, fifo_dout;

  assign start    = ioctl.ioctl_download && (ioctl.ioctl_index == IDX_ROM);
  assign accept   = (state == ST_LOAD) && ioctl.ioctl_wr && (ioctl.ioctl_index == IDX_ROM);
  assign in_range = ioctl.ioctl_addr < 25'(TOTAL);
  assign push     = accept && in_range && !fifo_full;
  assign err_set  = accept && (!in_range || fifo_full);
  assign pop      = rom.rom_wr && rom.rom_ready;
  assign rom_init = (state == ST_LOAD) || (state == ST_DRAIN);

  // Region and region-relative address are resolved before the byte is queued.
  always_comb begin
    region = decode_region(ioctl.ioctl_addr, 25'(R1_BASE), 25'(R2_BASE), 25'(R3_BASE));
    case (region)
      REG_BG:  base = R1_BASE;
      REG_SPR: base = R2_BASE;
      REG_SND: base = R3_BASE;
      default: base = '0;
    endcase
    rel_addr = ioctl.ioctl_addr[ADDR_W-1:0] - base;
    fifo_din = {region, rel_addr, ioctl.ioctl_dout};
  end

  rom_fifo2 #(.W(FW)) u_fifo (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .push       (push),
    .din        (fifo_din),
    .pop        (pop),
    .dout       (fifo_dout),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level_next (level_next)
  );

  assign rom.rom_wr     = !fifo_empty;
  assign rom.rom_region = fifo_dout[FW-1 -: 4];
  assign rom.rom_addr   = fifo_dout[8 +: ADDR_W];
  assign rom.rom_data   = fifo_dout[7:0];

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_next = ST_LOAD;
      ST_LOAD:          if (!ioctl.ioctl_download) state_next = ST_DRAIN;
      ST_DRAIN:         if (fifo_empty) state_next = start ? ST_LOAD : ST_DONE;
      default:          state_next = ST_IDLE;
    endcase
    enter_load = (state_next == ST_LOAD) && (state != ST_LOAD);
    done_set   = (state == ST_DRAIN) && (state_next == ST_DONE);
    drain_hold = (state_next == ST_DRAIN) && start;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      ioctl.ioctl_wait <= 1'b0;
      dip_sw           <= 8'h00;
      load_done        <= 1'b0;
      load_err         <= 1'b0;
      checksum         <= 16'h0000;
    end else begin
      state            <= state_next;
      ioctl.ioctl_wait <= (level_next != 2'd0) || drain_hold;
      if (ioctl.ioctl_wr && (ioctl.ioctl_index == IDX_DIP) && (ioctl.ioctl_addr == 25'd0))
        dip_sw <= ioctl.ioctl_dout;
      if (enter_load) begin
        checksum  <= 16'h0000;
        load_done <= 1'b0;
        load_err  <= 1'b0;
      end else begin
        if (pop)      checksum  <= checksum + {8'h00, rom.rom_data};
        if (done_set) load_done <= 1'b1;
        if (err_set)  load_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qbert_rom_loader.sv
// Directed self-checking bench for qbert_rom_loader: reset, image decode,
// backpressure, out-of-range, DIP capture and reset during a load.
module tb_qbert_rom_loader;
  import qbert_rom_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        rom_init, load_done, load_err;
  logic [7:0]  dip_sw;
  logic [15:0] checksum;
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [15:0] sum_model;

  ioctl_if io ();
  rom_if #(.ADDR_W(17)) rb ();

  qbert_rom_loader dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ioctl     (io),
    .rom       (rb),
    .rom_init  (rom_init),
    .dip_sw    (dip_sw),
    .load_done (load_done),
    .load_err  (load_err),
    .checksum  (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic apply_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    io.ioctl_index = idx;
    io.ioctl_addr  = a;
    io.ioctl_dout  = d;
    io.ioctl_wr    = 1'b1;
    step();
    io.ioctl_wr    = 1'b0;
  endtask

  task automatic test_reset();
    io.ioctl_download = 1'b0;
    io.ioctl_index    = 8'd0;
    io.ioctl_wr       = 1'b0;
    io.ioctl_addr     = 25'd0;
    io.ioctl_dout     = 8'd0;
    rb.rom_ready      = 1'b0;
    reset_n           = 1'b0;
    repeat (3) step();
    tests_run++;
    if ({rb.rom_wr, rb.rom_region, rb.rom_addr, rb.rom_data} !== 30'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rom_bus: got %h expected 0",
               {rb.rom_wr, rb.rom_region, rb.rom_addr, rb.rom_data});
    end
    tests_run++;
    if ({io.ioctl_wait, rom_init, dip_sw, load_done, load_err, checksum} !== 28'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_status: got %h expected 0",
               {io.ioctl_wait, rom_init, dip_sw, load_done, load_err, checksum});
    end
    reset_n = 1'b1;
    step();
    tests_run++;
    if (io.ioctl_wait !== 1'b0 || rb.rom_wr !== 1'b0 || rom_init !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: got wait=%b wr=%b init=%b expected 0 0 0",
               io.ioctl_wait, rb.rom_wr, rom_init);
    end
  endtask

  // Streams one byte per cycle; the head after each edge is the byte just pushed.
  task automatic stream_range(input logic [24:0] lo, input logic [24:0] hi);
    for (logic [24:0] a = lo; a <= hi; a++) begin
      io.ioctl_index = IDX_ROM;
      io.ioctl_addr  = a;
      io.ioctl_dout  = a[7:0];
      io.ioctl_wr    = 1'b1;
      step();
      sum_model = sum_model + {8'h00, a[7:0]};
      if (a == 25'h09FFF) begin
        tests_run++;
        if (rb.rom_wr !== 1'b1 || rb.rom_region !== 4'b0001 || rb.rom_addr !== 17'h09FFF) begin
          tests_failed++;
          $display("[TB] FAIL cpu_last: got wr=%b reg=%b addr=%h expected 1 0001 09fff",
                   rb.rom_wr, rb.rom_region, rb.rom_addr);
        end
      end
      if (a == 25'h0A000) begin
        tests_run++;
        if (rb.rom_region !== 4'b0010 || rb.rom_addr !== 17'h0 || rb.rom_data !== 8'h00) begin
          tests_failed++;
          $display("[TB] FAIL bg_first: got reg=%b addr=%h data=%h expected 0010 00000 00",
                   rb.rom_region, rb.rom_addr, rb.rom_data);
        end
      end
      if (a == 25'h0E000) begin
        tests_run++;
        if (rb.rom_region !== 4'b0100 || rb.rom_addr !== 17'h0) begin
          tests_failed++;
          $display("[TB] FAIL spr_first: got reg=%b addr=%h expected 0100 00000",
                   rb.rom_region, rb.rom_addr);
        end
      end
      if (a == 25'h16000) begin
        tests_run++;
        if (rb.rom_region !== 4'b1000 || rb.rom_addr !== 17'h0) begin
          tests_failed++;
          $display("[TB] FAIL snd_first: got reg=%b addr=%h expected 1000 00000",
                   rb.rom_region, rb.rom_addr);
        end
      end
      if (a == 25'h16FFF) begin
        tests_run++;
        if (rb.rom_region !== 4'b1000 || rb.rom_addr !== 17'h00FFF || rb.rom_data !== 8'hFF) begin
          tests_failed++;
          $display("[TB] FAIL snd_last: got reg=%b addr=%h data=%h expected 1000 00fff ff",
                   rb.rom_region, rb.rom_addr, rb.rom_data);
        end
      end
    end
    io.ioctl_wr = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 10 && load_done !== 1'b1; i++) step();
    tests_run++;
    if (load_done !== 1'b1 || rom_init !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s: got done=%b init=%b expected 1 0", name, load_done, rom_init);
    end
  endtask

  task automatic test_full_image();
    rb.rom_ready      = 1'b1;
    sum_model         = 16'h0;
    io.ioctl_index    = IDX_ROM;
    io.ioctl_download = 1'b1;
    step();
    tests_run++;
    if (rom_init !== 1'b1 || checksum !== 16'h0) begin
      tests_failed++;
      $display("[TB] FAIL load_entry: got init=%b sum=%h expected 1 0000", rom_init, checksum);
    end
    stream_range(25'h00000, 25'h0003F);
    stream_range(25'h09FC0, 25'h0A03F);
    stream_range(25'h0DFC0, 25'h0E03F);
    stream_range(25'h15FC0, 25'h1603F);
    stream_range(25'h16F00, 25'h16FFF);
    io.ioctl_download = 1'b0;
    wait_done("image_done");
    tests_run++;
    if (checksum !== sum_model || load_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL image_checksum: got %h err=%b expected %h err=0",
               checksum, load_err, sum_model);
    end
  endtask

  task automatic test_backpressure();
    rb.rom_ready      = 1'b0;
    io.ioctl_index    = IDX_ROM;
    io.ioctl_download = 1'b1;
    step();
    tests_run++;
    if (load_done !== 1'b0 || checksum !== 16'h0) begin
      tests_failed++;
      $display("[TB] FAIL reload_clear: got done=%b sum=%h expected 0 0000", load_done, checksum);
    end
    apply_byte(IDX_ROM, 25'd0, 8'h5A);
    tests_run++;
    if (io.ioctl_wait !== 1'b1 || rb.rom_wr !== 1'b1 || rb.rom_data !== 8'h5A) begin
      tests_failed++;
      $display("[TB] FAIL bp_first: got wait=%b wr=%b data=%h expected 1 1 5a",
               io.ioctl_wait, rb.rom_wr, rb.rom_data);
    end
    apply_byte(IDX_ROM, 25'd1, 8'hA5);
    repeat (3) step();
    tests_run++;
    if (io.ioctl_wait !== 1'b1 || rb.rom_wr !== 1'b1 || rb.rom_data !== 8'h5A ||
        rb.rom_addr !== 17'h0) begin
      tests_failed++;
      $display("[TB] FAIL bp_hold: got wait=%b wr=%b data=%h addr=%h expected 1 1 5a 00000",
               io.ioctl_wait, rb.rom_wr, rb.rom_data, rb.rom_addr);
    end
    rb.rom_ready = 1'b1;
    step();
    tests_run++;
    if (rb.rom_wr !== 1'b1 || rb.rom_data !== 8'hA5 || rb.rom_addr !== 17'h1 ||
        checksum !== 16'h005A) begin
      tests_failed++;
      $display("[TB] FAIL bp_second: got wr=%b data=%h addr=%h sum=%h expected 1 a5 00001 005a",
               rb.rom_wr, rb.rom_data, rb.rom_addr, checksum);
    end
    step();
    tests_run++;
    if (rb.rom_wr !== 1'b0 || io.ioctl_wait !== 1'b0 || checksum !== 16'h00FF) begin
      tests_failed++;
      $display("[TB] FAIL bp_drained: got wr=%b wait=%b sum=%h expected 0 0 00ff",
               rb.rom_wr, io.ioctl_wait, checksum);
    end
  endtask

  task automatic test_out_of_range();
    apply_byte(IDX_ROM, 25'h17000, 8'h77);
    tests_run++;
    if (rb.rom_wr !== 1'b0 || load_err !== 1'b1 || checksum !== 16'h00FF) begin
      tests_failed++;
      $display("[TB] FAIL oor_drop: got wr=%b err=%b sum=%h expected 0 1 00ff",
               rb.rom_wr, load_err, checksum);
    end
    io.ioctl_download = 1'b0;
    wait_done("oor_done");
    tests_run++;
    if (load_err !== 1'b1 || checksum !== 16'h00FF) begin
      tests_failed++;
      $display("[TB] FAIL oor_sticky: got err=%b sum=%h expected 1 00ff", load_err, checksum);
    end
  endtask

  task automatic test_dip_capture();
    io.ioctl_index    = IDX_DIP;
    io.ioctl_download = 1'b1;
    apply_byte(IDX_DIP, 25'd0, 8'hC3);
    tests_run++;
    if (dip_sw !== 8'hC3 || rb.rom_wr !== 1'b0 || rom_init !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL dip_load: got dip=%h wr=%b init=%b expected c3 0 0",
               dip_sw, rb.rom_wr, rom_init);
    end
    apply_byte(IDX_DIP, 25'd1, 8'hFF);
    tests_run++;
    if (dip_sw !== 8'hC3 || rb.rom_wr !== 1'b0 || checksum !== 16'h00FF) begin
      tests_failed++;
      $display("[TB] FAIL dip_ignore: got dip=%h wr=%b sum=%h expected c3 0 00ff",
               dip_sw, rb.rom_wr, checksum);
    end
    io.ioctl_download = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_load();
    rb.rom_ready      = 1'b0;
    io.ioctl_index    = IDX_ROM;
    io.ioctl_download = 1'b1;
    step();
    apply_byte(IDX_ROM, 25'h00010, 8'h11);
    apply_byte(IDX_ROM, 25'h00011, 8'h22);
    tests_run++;
    if (rb.rom_wr !== 1'b1 || io.ioctl_wait !== 1'b1 || load_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_queued: got wr=%b wait=%b err=%b expected 1 1 0",
               rb.rom_wr, io.ioctl_wait, load_err);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (rb.rom_wr !== 1'b0 || rom_init !== 1'b0 || io.ioctl_wait !== 1'b0 ||
        rb.rom_data !== 8'h00 || dip_sw !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: got wr=%b init=%b wait=%b data=%h dip=%h expected 0 0 0 00 00",
               rb.rom_wr, rom_init, io.ioctl_wait, rb.rom_data, dip_sw);
    end
    step();
    reset_n      = 1'b1;
    rb.rom_ready = 1'b1;
    step();
    tests_run++;
    if (rom_init !== 1'b1 || checksum !== 16'h0 || rb.rom_wr !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL restart_entry: got init=%b sum=%h wr=%b expected 1 0000 0",
               rom_init, checksum, rb.rom_wr);
    end
    apply_byte(IDX_ROM, 25'h00020, 8'h33);
    step();
    tests_run++;
    if (checksum !== 16'h0033 || rb.rom_wr !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL restart_sum: got sum=%h wr=%b expected 0033 0", checksum, rb.rom_wr);
    end
    io.ioctl_download = 1'b0;
    wait_done("restart_done");
  endtask

  initial begin
    test_reset();
    test_full_image();
    test_backpressure();
    test_out_of_range();
    test_dip_capture();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
